// File: rtl/pkt_ingress_buffer.sv
// -----------------------------------------------------------------------------
// pkt_ingress_buffer
//
// Ingress stage in front of the depacketizer. Router packets arrive on a
// valid/ready channel and are queued in a small FIFO. The head packet is split
// into an opcode channel and a data channel. The head entry retires only once
// both channels have completed their handshakes (fork/join).
//
// Ports
//   clk         in   1                 rising-edge clock
//   rst_n       in   1                 asynchronous active-low reset
//   in_pkt      in   ADDR_HI+1         packet from the router
//   in_valid    in   1                 in_pkt valid
//   in_ready    out  1                 buffer can accept a packet
//   op_out      out  OP_HI-OP_LO+1     opcode field of the head packet (0 when empty)
//   op_valid    out  1                 opcode pending for the head packet
//   op_ready    in   1                 consumer takes the opcode
//   data_out    out  DATA_HI-DATA_LO+1 data field of the head packet (0 when empty)
//   data_valid  out  1                 data pending for the head packet
//   data_ready  in   1                 consumer takes the data
//   fifo_count  out  $clog2(DEPTH)+1   current occupancy
//   drop_count  out  16                saturating count of filtered packets
//
// Build option
//   PKT_ADDR_FILTER_EN : when defined, packets whose address field differs from
//                        NODE_ADDR are accepted but discarded and counted in
//                        drop_count. When undefined, every packet is queued and
//                        drop_count is tied to 0.
// -----------------------------------------------------------------------------
module pkt_ingress_buffer #(
  parameter int ADDR_HI   = 32,
  parameter int ADDR_LO   = 29,
  parameter int OP_HI     = 28,
  parameter int OP_LO     = 25,
  parameter int DATA_HI   = 24,
  parameter int DATA_LO   = 0,
  parameter int DEPTH     = 4,
  parameter int NODE_ADDR = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_HI:0]           in_pkt,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OP_HI-OP_LO:0]       op_out,
  output logic                       op_valid,
  input  logic                       op_ready,
  output logic [DATA_HI-DATA_LO:0]   data_out,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                drop_count
);

  localparam int ADDR_W = ADDR_HI - ADDR_LO + 1;
  localparam int OP_W   = OP_HI - OP_LO + 1;
  localparam int DATA_W = DATA_HI - DATA_LO + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [ADDR_W-1:0] NODE_ADDR_V = ADDR_W'(NODE_ADDR);
  localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(DEPTH);

  // Only the fields the downstream consumers need are stored.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Progress of the current head entry through its two output channels.
  typedef enum logic [1:0] {
    ST_BOTH      = 2'd0,  // neither channel taken yet
    ST_NEED_DATA = 2'd1,  // opcode taken, data outstanding
    ST_NEED_OP   = 2'd2   // data taken, opcode outstanding
  } head_state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  head_state_e        state_q, state_d;
  logic               op_valid_q, data_valid_q;
  logic               op_valid_d, data_valid_d;

  logic               push_hs;    // input handshake completes
  logic               addr_match; // packet is destined for this node
  logic               wr_en;      // packet is actually written into the FIFO
  logic               op_hs, data_hs;
  logic               pop;
  entry_t             head;

  // in_ready depends only on the registered count, so a pop in the same cycle
  // never lets a push through a full FIFO.
  assign in_ready = (count_q != FULL_COUNT);
  assign push_hs  = in_valid && in_ready;
  assign wr_en    = push_hs && addr_match;

  assign op_hs    = op_valid_q   && op_ready;
  assign data_hs  = data_valid_q && data_ready;

  assign head     = mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Optional destination-address filter
  // ---------------------------------------------------------------------------
`ifdef PKT_ADDR_FILTER_EN
  logic [15:0] drop_q;

  assign addr_match = (in_pkt[ADDR_HI:ADDR_LO] == NODE_ADDR_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (push_hs && !addr_match && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  logic unused_addr;

  assign addr_match  = 1'b1;
  assign drop_count  = '0;
  // The address field and node address only matter when the filter is built.
  assign unused_addr = ^{in_pkt[ADDR_HI:ADDR_LO], NODE_ADDR_V};
`endif

  // ---------------------------------------------------------------------------
  // Head FSM next-state and pop decision
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise a latch would be inferred.
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_BOTH: begin
        if (op_hs && data_hs) begin
          pop = 1'b1;                  // both taken together: retire at once
        end else if (op_hs) begin
          state_d = ST_NEED_DATA;
        end else if (data_hs) begin
          state_d = ST_NEED_OP;
        end
      end
      ST_NEED_DATA: begin
        if (data_hs) begin
          pop     = 1'b1;
          state_d = ST_BOTH;
        end
      end
      ST_NEED_OP: begin
        if (op_hs) begin
          pop     = 1'b1;
          state_d = ST_BOTH;
        end
      end
      default: state_d = ST_BOTH;
    endcase
  end

  // Occupancy: push and pop in the same cycle leave the count unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Valids are registered: they are computed from the post-edge occupancy and
  // head state, so a packet written into an empty FIFO is visible on the very
  // next cycle, and a channel already taken stays low until the entry retires.
  assign op_valid_d   = (count_d != '0) && (state_d != ST_NEED_DATA);
  assign data_valid_d = (count_d != '0) && (state_d != ST_NEED_OP);

  // ---------------------------------------------------------------------------
  // Head FSM with registered channel valids
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before this edge, independent of order.
    if (!rst_n) begin
      state_q      <= ST_BOTH;
      op_valid_q   <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_valid_q   <= op_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // after it has been written, and the outputs are gated to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= '{op:   in_pkt[OP_HI:OP_LO],
                         data: in_pkt[DATA_HI:DATA_LO]};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign op_out     = (count_q != '0) ? head.op   : '0;
  assign data_out   = (count_q != '0) ? head.data : '0;
  assign op_valid   = op_valid_q;
  assign data_valid = data_valid_q;
  assign fifo_count = count_q;

endmodule
